// File: rtl/contador_pkg.sv
// contador_pkg: direction/mode encodings and the bin->Gray helper shared by the counter and its bench.
package contador_pkg;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/contador_param_if.sv
// contador_param_if: control/data bus of the parametrised counter.
// q_gray is present only when CONTADOR_GRAY_EN is defined.
interface contador_param_if #(parameter int unsigned WIDTH = 3);
   logic             en;
   logic             load;
   logic             dir;
   logic             sat;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;
`ifdef CONTADOR_GRAY_EN
   logic [WIDTH-1:0] q_gray;
   modport master (output en, load, dir, sat, d, input q, tc, ovf, q_gray);
   modport slave  (input en, load, dir, sat, d, output q, tc, ovf, q_gray);
`else
   modport master (output en, load, dir, sat, d, input q, tc, ovf);
   modport slave  (input en, load, dir, sat, d, output q, tc, ovf);
`endif
endinterface

// File: rtl/contador_gray_enc.sv
// contador_gray_enc: combinational binary to Gray encoder.
module contador_gray_enc #(parameter int unsigned WIDTH = 3) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/contador_param.sv
// contador_param: up/down modulo counter with load, wrap/saturate, tc and ovf.
// Define CONTADOR_GRAY_EN to add the registered Gray-coded output q_gray.
module contador_param
   import contador_pkg::*;
#(
   parameter int unsigned      WIDTH   = 3,
   parameter longint unsigned  MODULO  = 64'd1 << WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic             clk,
   input logic             rst_n,
   contador_param_if.slave bus_if
);
   // MODULO may be 2**WIDTH, so only MODULO-1 is ever held in WIDTH bits
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 64'd1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             bnd;

   always_comb begin
      bnd   = (bus_if.dir == DIR_UP) ? (q_q == MAX) : (q_q == '0);
      q_d   = q_q;
      ovf_d = 1'b0;
      if (bus_if.load)
         q_d = (64'(bus_if.d) >= MODULO) ? MAX : bus_if.d;
      else if (bus_if.en) begin
         ovf_d = bnd;
         q_d   = !bnd ? ((bus_if.dir == DIR_UP) ? q_q + WIDTH'(1) : q_q - WIDTH'(1))
               : (bus_if.sat == MODE_SAT) ? q_q
               : ((bus_if.dir == DIR_UP) ? '0 : MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q_q   <= RST_VAL;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end

   assign bus_if.q   = q_q;
   assign bus_if.ovf = ovf_q;
   assign bus_if.tc  = bus_if.en & bnd;

`ifdef CONTADOR_GRAY_EN
   logic [WIDTH-1:0] g_d, g_q;

   contador_gray_enc #(.WIDTH(WIDTH)) u_gray (.bin_i(q_d), .gray_o(g_d));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) g_q <= WIDTH'(bin2gray(32'(RST_VAL)));
      else        g_q <= g_d;

   assign bus_if.q_gray = g_q;
`endif
endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: randomized + directed check of two counters (MODULO 6 and 8) against a range-arithmetic model.
// Gray output checks are compiled in only with CONTADOR_GRAY_EN.
module tb_contador_param;
   import contador_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_r, load_r, dir_r, sat_r;
   logic [2:0] d_r;
   int         n_chk = 0;
   int         n_fail = 0;
   int         mq[2];
   int         movf[2];
   int         mmod[2] = '{6, 8};
   logic [2:0] gtbl[8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
   int         seq2[8] = '{1, 2, 3, 4, 5, 0, 1, 2};

   always #5 clk = ~clk;

   contador_param_if #(.WIDTH(3)) ifa ();
   contador_param_if #(.WIDTH(3)) ifb ();

   assign ifa.en = en_r;
   assign ifa.load = load_r;
   assign ifa.dir = dir_r;
   assign ifa.sat = sat_r;
   assign ifa.d = d_r;
   assign ifb.en = en_r;
   assign ifb.load = load_r;
   assign ifb.dir = dir_r;
   assign ifb.sat = sat_r;
   assign ifb.d = d_r;

   contador_param #(.WIDTH(3), .MODULO(64'd6), .RST_VAL(3'd0)) dut_a (.clk(clk), .rst_n(rst_n), .bus_if(ifa));
   contador_param #(.WIDTH(3), .MODULO(64'd8), .RST_VAL(3'd0)) dut_b (.clk(clk), .rst_n(rst_n), .bus_if(ifb));

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic e, input logic l, input logic dr, input logic s, input logic [2:0] dv);
      en_r = e;
      load_r = l;
      dir_r = dr;
      sat_r = s;
      d_r = dv;
   endtask

   // tc: enabled and one more step would leave 0..M-1
   function automatic int exp_tc(input int k);
      int n;
      n = dir_r ? mq[k] + 1 : mq[k] - 1;
      return int'(en_r && (n < 0 || n >= mmod[k]));
   endfunction

   task automatic model_edge();
      int n;
      for (int k = 0; k < 2; k++) begin
         if (load_r) begin
            mq[k] = (int'(d_r) >= mmod[k]) ? mmod[k] - 1 : int'(d_r);
            movf[k] = 0;
         end else if (en_r) begin
            n = dir_r ? mq[k] + 1 : mq[k] - 1;
            if (n < 0 || n >= mmod[k]) begin
               movf[k] = 1;
               if (!sat_r) mq[k] = (n + mmod[k]) % mmod[k];
            end else begin
               mq[k] = n;
               movf[k] = 0;
            end
         end else
            movf[k] = 0;
      end
   endtask

   task automatic check_state(input string ph);
      chk({ph, "_q_a"}, ifa.q, mq[0]);
      chk({ph, "_ovf_a"}, ifa.ovf, movf[0]);
      chk({ph, "_q_b"}, ifb.q, mq[1]);
      chk({ph, "_ovf_b"}, ifb.ovf, movf[1]);
`ifdef CONTADOR_GRAY_EN
      chk({ph, "_gray_a"}, ifa.q_gray, bin2gray(32'(mq[0])) & 32'h7);
      chk({ph, "_gray_b"}, ifb.q_gray, bin2gray(32'(mq[1])) & 32'h7);
`endif
   endtask

   task automatic tick();
      #1;
      chk("tc_a", ifa.tc, exp_tc(0));
      chk("tc_b", ifb.tc, exp_tc(1));
      @(posedge clk);
      model_edge();
      #1;
      check_state("edge");
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 1, 0, 3'd0);
      mq = '{0, 0};
      movf = '{0, 0};
      #3;
      check_state("rst");
      @(negedge clk);
      rst_n = 1'b1;
      // up/wrap from 0
      drive(1, 0, 1, 0, 3'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("up_seq_a", ifa.q, seq2[i]);
      end
      // down/saturate from 1
      drive(0, 1, 0, 0, 3'd1);
      tick();
      drive(1, 0, 0, 1, 3'd0);
      repeat (4) tick();
      chk("sat_hold_a", ifa.q, 0);
      chk("sat_ovf_a", ifa.ovf, 1);
      // clamped load, then wrap
      drive(1, 1, 1, 0, 3'd7);
      tick();
      chk("clamp_a", ifa.q, 5);
      chk("clamp_b", ifb.q, 7);
      drive(1, 0, 1, 0, 3'd0);
      tick();
      chk("wrap_after_load_b", ifb.q, 0);
      // hold with en=0, then count down
      drive(0, 1, 1, 0, 3'd3);
      tick();
      drive(0, 0, 1, 0, 3'd0);
      repeat (3) tick();
      drive(1, 0, 0, 0, 3'd0);
      tick();
      chk("down_after_hold_a", ifa.q, 2);
      // async reset mid-count
      drive(0, 1, 1, 0, 3'd4);
      tick();
      drive(1, 0, 1, 0, 3'd0);
      #2 rst_n = 1'b0;
      mq = '{0, 0};
      movf = '{0, 0};
      #1;
      check_state("async_rst");
      @(posedge clk);
      #1;
      check_state("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("post_rst_a", ifa.q, 2);
      // full up sweep on the MODULO=8 counter
      drive(0, 1, 1, 0, 3'd0);
      tick();
`ifdef CONTADOR_GRAY_EN
      chk("gray_sweep", ifb.q_gray, gtbl[0]);
`endif
      drive(1, 0, 1, 0, 3'd0);
      for (int i = 1; i < 8; i++) begin
         tick();
`ifdef CONTADOR_GRAY_EN
         chk("gray_sweep", ifb.q_gray, gtbl[i]);
`endif
      end
      // random traffic
      repeat (400) begin
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
               3'($urandom));
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
